// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage hazard controller for the 5-stage MIPS core
//   Detects load-use and MDU-busy hazards and stalls for them over several cycles.
//   Flushes IF/ID on redirects resolved in ID.
// Ports:
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   ID_rs, ID_rt               source registers of the ID instruction
//   ID_use_rs, ID_use_rt       ID instruction actually reads rs / rt
//   EX_rt, EX_MemRead          destination register of the EX instruction, EX is a load
//   ID_PCSrc                   next-PC select resolved in ID
//   ID_MDU_start, ID_MDU_read  ID holds mult/div, ID holds mfhi/mflo
//   PC_unchanged, IF_ID_hold   hold PC, hold IF/ID
//   IF_ID_flush, ID_EX_flush   bubble into IF/ID, bubble into ID/EX
//   MDU_busy                   HI/LO not yet valid
module hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int PCSRC_W = 3,
    parameter logic [PCSRC_W-1:0] NPC_PLUS4 = '0,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT = 4,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_W-1:0]   ID_rs,
    input  logic [REG_W-1:0]   ID_rt,
    input  logic               ID_use_rs,
    input  logic               ID_use_rt,
    input  logic [REG_W-1:0]   EX_rt,
    input  logic               EX_MemRead,
    input  logic [PCSRC_W-1:0] ID_PCSrc,
    input  logic               ID_MDU_start,
    input  logic               ID_MDU_read,
    output logic               PC_unchanged,
    output logic               IF_ID_hold,
    output logic               IF_ID_flush,
    output logic               ID_EX_flush,
    output logic               MDU_busy
);
    typedef enum logic {IDLE, LSTALL} state_t;
    localparam logic [2:0] LD_INIT = 3'(LOAD_LAT - 1);
    // The start cycle itself counts toward the latency, so HI/LO is readable
    // MDU_LAT cycles after the start and the busy window is one shorter.
    localparam logic [4:0] MDU_INIT = 5'(MDU_LAT - 1);
    localparam logic [1:0] FL_INIT = 2'(FLUSH_DEPTH - 1);
    state_t     state;
    logic [2:0] ld_cnt;
    logic [4:0] mdu_cnt;
    logic [1:0] fl_cnt;
    logic       rst_q;
    logic       quiet;
    logic       ld_hit;
    logic       busy;
    logic       stall;
    logic       redirect;
    logic       flushing;
    // Outputs stay low during reset and the cycle after it; inputs seen then are ignored.
    assign quiet = rst || rst_q;
    assign ld_hit = EX_MemRead && EX_rt != '0 &&
                    ((ID_use_rs && ID_rs == EX_rt) || (ID_use_rt && ID_rt == EX_rt));
    assign busy = mdu_cnt != '0;
    assign stall = !quiet && (state == LSTALL || ld_hit ||
                              (busy && (ID_MDU_read || ID_MDU_start)));
    // A redirect under stall is not taken; the branch stays in ID and retries.
    assign redirect = !quiet && ID_PCSrc != NPC_PLUS4 && !stall;
    assign flushing = fl_cnt != '0;
    assign PC_unchanged = stall;
    assign ID_EX_flush = stall;
    // An outstanding flush wins over hold so IF/ID never gets both.
    assign IF_ID_hold = stall && !flushing;
    assign IF_ID_flush = !quiet && (redirect || flushing);
    assign MDU_busy = !quiet && busy;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ld_cnt <= '0;
            mdu_cnt <= '0;
            fl_cnt <= '0;
            rst_q <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            if (state == LSTALL) begin
                ld_cnt <= ld_cnt - 3'd1;
                state <= ld_cnt == 3'd1 ? IDLE : LSTALL;
            end else if (!quiet && ld_hit && LOAD_LAT > 1) begin
                state <= LSTALL;
                ld_cnt <= LD_INIT;
            end
            mdu_cnt <= (!quiet && ID_MDU_start && !stall) ? MDU_INIT :
                       busy ? mdu_cnt - 5'd1 : mdu_cnt;
            fl_cnt <= redirect ? FL_INIT : flushing ? fl_cnt - 2'd1 : fl_cnt;
        end
    end
endmodule
